sht40_measure_sequencer: RTL and testbench
==========================================

Name: sht40_measure_sequencer

Overview:
Sequences the I2C master through complete SHT40 measurement cycles: command write, conversion wait, then a 6-byte read. Checks both CRC-8 words, publishes temperature and humidity words with a valid strobe, and retries on NACK, short read, CRC failure or timeout. Sits between the processor-side trigger logic and i2c_master, and owns the master's request inputs.

Parameters:
SHT_ADDR, 7'h44, 7-bit peripheral address driven on Peripheral_Address.
MEAS_WAIT_CYCLES, 20000, clk cycles from write completion to read request.
PERIOD_CYCLES, 200000, clk cycles between periodic triggers, measured from the start of the previous measurement.
TIMEOUT_CYCLES, 50000, maximum clk cycles the block waits in any master-wait state.
MAX_RETRIES, 3, number of retries after the first failed attempt before giving up.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
Measure_Enable  in  1  enables periodic triggering
Measure_Now  in  1  single-shot trigger; sampled only in IDLE
Precision_Sel  in  2  command select: 0 gives 0xFD, 1 gives 0xF6, 2 and 3 give 0xE0
Master_State_Out  in  3  master state; 3'b000 means idle
Frames_Read  in  1  one-cycle pulse per received byte
Data_Received  in  8  received byte, valid while Frames_Read is high
Nack_Received  in  1  one-cycle pulse when the master sees a NACK
Processor_Ready  out  1  transaction request to the master
i2c_writes  out  1  1 selects write, 0 selects read
Peripheral_Address  out  7  always SHT_ADDR
Command_Data_Frames  out  8  latched command byte
Temperature_Output  out  16  last good temperature word
Humidity_Output  out  16  last good humidity word
Sample_Valid  out  1  one-cycle pulse when the outputs update
CRC_Error  out  1  one-cycle pulse per CRC mismatch
Meas_Fail  out  1  one-cycle pulse when retries are exhausted
Error_Count  out  8  failed measurements, saturates at 255
Busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (synchronous, applied at the next edge, including mid-transaction):
  - state = IDLE, every counter = 0, Processor_Ready = 0, i2c_writes = 1.
  - Command_Data_Frames = 8'hFD.
  - Temperature_Output = Humidity_Output = 0, Error_Count = 0.
  - All pulse outputs = 0.
- IDLE
  - Trigger = Measure_Now, or Measure_Enable with the period counter reaching PERIOD_CYCLES-1.
  - The period counter runs only while Measure_Enable is high. It clears on trigger and on Measure_Enable going low.
  - On trigger: latch the command from Precision_Sel, clear the retry counter, go to WR_REQ.
  - Measure_Now outside IDLE is ignored (no queueing).
- WR_REQ: Processor_Ready = 1, i2c_writes = 1. When Master_State_Out != 0, drop Processor_Ready on the next cycle and go to WR_WAIT.
- WR_WAIT: Master_State_Out == 0 goes to MEAS_WAIT. Nack_Received goes to FAIL.
- MEAS_WAIT: count MEAS_WAIT_CYCLES, then go to RD_REQ.
- RD_REQ: same handshake as WR_REQ with i2c_writes = 0, then go to RD_COLLECT.
- RD_COLLECT
  - Each Frames_Read pulse shifts Data_Received into a 48-bit register (MSB first) and increments the byte count (3 bits).
  - Pulses after the 6th byte are ignored.
  - Master_State_Out == 0 with byte count == 6 goes to CHECK.
  - Master_State_Out == 0 with byte count < 6, or Nack_Received, goes to FAIL.
- Timeout: in WR_REQ, WR_WAIT, RD_REQ and RD_COLLECT, a shared timeout counter reaching TIMEOUT_CYCLES goes to FAIL. The counter clears on every state change.
- CHECK (1 cycle)
  - CRC-8: polynomial 0x31, init 0xFF, no reflection, no final XOR, computed over bytes 0-1 and over bytes 3-4.
  - Compare against bytes 2 and 5.
  - Both match: Temperature_Output = {b0,b1}, Humidity_Output = {b3,b4}, Sample_Valid pulses, go to IDLE.
  - Either mismatches: CRC_Error pulses, outputs are held, go to FAIL.
- FAIL (1 cycle)
  - Retry counter < MAX_RETRIES: increment it, go to WR_REQ with the same latched command.
  - Otherwise: Meas_Fail pulses, Error_Count increments (saturating at 255), go to IDLE.
- Simultaneous Nack_Received and master idle in the same cycle: the NACK wins and the block goes to FAIL.
- Peripheral_Address is constant. Command_Data_Frames changes only on an IDLE trigger.

Test Plan:
1. Measure_Now pulse, master model returns BE EF 92 AB CD 6F -> write request with command 0xFD, read request MEAS_WAIT_CYCLES after the write completes; Temperature_Output = 16'hBEEF, Humidity_Output = 16'hABCD, one Sample_Valid pulse, Busy low afterwards.
2. Same stimulus with byte 5 = 0x6E -> CRC_Error pulse, retry re-issues 0xFD; if the model then returns good data, the outputs update; the previous outputs are held until then.
3. Nack_Received during every attempt, MAX_RETRIES = 3 -> 4 write requests, one Meas_Fail pulse, Error_Count = 1, no Sample_Valid.
4. Measure_Enable high, PERIOD_CYCLES = 100 in a reduced bench, Precision_Sel = 1 -> measurements start every 100 cycles with command 0xF6; Measure_Now pulses during Busy have no effect.
5. Master left stuck non-idle in RD_COLLECT -> FAIL after TIMEOUT_CYCLES, then retry.
6. rst asserted in MEAS_WAIT and in RD_COLLECT -> Processor_Ready = 0 and Busy = 0 the next cycle; all outputs at reset values; a subsequent Measure_Now runs a clean cycle.

Source files
------------

// File: rtl/sht40_measure_sequencer.sv
// sht40_measure_sequencer
// Drives i2c_master through SHT40 measurement cycles: command write, conversion
// wait, 6-byte read, CRC-8 check of both words, then publishes temperature and
// humidity. Failed attempts (NACK, short read, CRC mismatch, timeout) are
// retried up to MAX_RETRIES times before Meas_Fail is raised.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   Measure_Enable        periodic triggering enable
//   Measure_Now           single-shot trigger, honoured only in IDLE
//   Precision_Sel         0 -> 0xFD, 1 -> 0xF6, 2/3 -> 0xE0
//   Master_State_Out      master state, 0 = idle
//   Frames_Read           one pulse per received byte (Data_Received valid)
//   Nack_Received         pulse when the master sees a NACK
//   Processor_Ready       transaction request to the master
//   i2c_writes            1 = write, 0 = read
//   Peripheral_Address    constant SHT_ADDR
//   Command_Data_Frames   latched command byte
//   Temperature_Output    last good temperature word
//   Humidity_Output       last good humidity word
//   Sample_Valid          pulse when the outputs update
//   CRC_Error             pulse per CRC mismatch
//   Meas_Fail             pulse when retries are exhausted
//   Error_Count           failed measurements, saturating
//   Busy                  high outside IDLE
module sht40_measure_sequencer #(
  parameter logic [6:0]  SHT_ADDR         = 7'h44,
  parameter int unsigned MEAS_WAIT_CYCLES = 20000,
  parameter int unsigned PERIOD_CYCLES    = 200000,
  parameter int unsigned TIMEOUT_CYCLES   = 50000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Measure_Enable,
  input  logic        Measure_Now,
  input  logic [1:0]  Precision_Sel,
  input  logic [2:0]  Master_State_Out,
  input  logic        Frames_Read,
  input  logic [7:0]  Data_Received,
  input  logic        Nack_Received,
  output logic        Processor_Ready,
  output logic        i2c_writes,
  output logic [6:0]  Peripheral_Address,
  output logic [7:0]  Command_Data_Frames,
  output logic [15:0] Temperature_Output,
  output logic [15:0] Humidity_Output,
  output logic        Sample_Valid,
  output logic        CRC_Error,
  output logic        Meas_Fail,
  output logic [7:0]  Error_Count,
  output logic        Busy
);

  localparam logic [31:0] MEAS_LAST   = 32'(MEAS_WAIT_CYCLES - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_MEAS_WAIT,
    S_RD_REQ, S_RD_COLLECT, S_CHECK, S_FAIL
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;      // timeout / conversion-wait counter, cleared per state
  logic [31:0] r_per;      // period counter
  logic [7:0]  r_retry;
  logic [2:0]  r_bytes;
  logic [47:0] r_data;
  logic        r_ready;
  logic        r_writes;
  logic [7:0]  r_cmd;
  logic [15:0] r_temp;
  logic [15:0] r_hum;
  logic        r_valid;
  logic        r_crc_err;
  logic        r_meas_fail;
  logic [7:0]  r_err_cnt;

  logic        w_trigger;
  logic        w_master_busy;
  logic        w_timeout;
  logic [7:0]  w_cmd;
  logic        w_crc_ok;

  // CRC-8, poly 0x31, init 0xFF, MSB first, no final XOR
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0]  c;
    logic [15:0] s;
    c = 8'hFF;
    s = d;
    for (int unsigned i = 0; i < 16; i++) begin
      if (c[7] ^ s[15]) c = {c[6:0], 1'b0} ^ 8'h31;
      else              c = {c[6:0], 1'b0};
      s = {s[14:0], 1'b0};
    end
    return c;
  endfunction

  assign w_trigger     = Measure_Now || (Measure_Enable && (r_per == PERIOD_LAST));
  assign w_master_busy = (Master_State_Out != 3'b000);
  assign w_timeout     = (r_cnt == TO_LAST);
  assign w_cmd         = (Precision_Sel == 2'd0) ? 8'hFD :
                         (Precision_Sel == 2'd1) ? 8'hF6 : 8'hE0;
  assign w_crc_ok      = (crc8(r_data[47:32]) == r_data[31:24]) &&
                         (crc8(r_data[23:8])  == r_data[7:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_per       <= '0;
      r_retry     <= '0;
      r_bytes     <= '0;
      r_data      <= '0;
      r_ready     <= 1'b0;
      r_writes    <= 1'b1;
      r_cmd       <= 8'hFD;
      r_temp      <= '0;
      r_hum       <= '0;
      r_valid     <= 1'b0;
      r_crc_err   <= 1'b0;
      r_meas_fail <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_valid     <= 1'b0;
      r_crc_err   <= 1'b0;
      r_meas_fail <= 1'b0;
      // Processor_Ready is re-asserted explicitly on every cycle spent
      // in (or entering) a request state, so it drops on any exit.
      r_ready     <= 1'b0;

      // Period counter keeps running while busy and parks at its last
      // value, so an overdue trigger fires as soon as IDLE is reached.
      if (!Measure_Enable)          r_per <= '0;
      else if (r_per != PERIOD_LAST) r_per <= r_per + 32'd1;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_trigger) begin
            r_cmd    <= w_cmd;
            r_retry  <= '0;
            r_per    <= '0;
            r_writes <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= S_WR_REQ;
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          if (w_master_busy) begin
            r_cnt   <= '0;
            r_bytes <= '0;
            r_data  <= '0;
            r_state <= (r_state == S_WR_REQ) ? S_WR_WAIT : S_RD_COLLECT;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_state <= S_FAIL;
          end else begin
            r_cnt   <= r_cnt + 32'd1;
            r_ready <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          r_cnt <= r_cnt + 32'd1;
          if (Nack_Received) begin
            r_cnt   <= '0;
            r_state <= S_FAIL;
          end else if (!w_master_busy) begin
            r_cnt   <= '0;
            r_state <= S_MEAS_WAIT;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_state <= S_FAIL;
          end
        end
        S_MEAS_WAIT: begin
          if (r_cnt == MEAS_LAST) begin
            r_cnt    <= '0;
            r_writes <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= S_RD_REQ;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RD_COLLECT: begin
          r_cnt <= r_cnt + 32'd1;
          if (Frames_Read && (r_bytes != 3'd6)) begin
            r_data  <= {r_data[39:0], Data_Received};
            r_bytes <= r_bytes + 3'd1;
          end
          if (Nack_Received) begin
            r_cnt   <= '0;
            r_state <= S_FAIL;
          end else if (!w_master_busy) begin
            r_cnt   <= '0;
            r_state <= (r_bytes == 3'd6) ? S_CHECK : S_FAIL;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_state <= S_FAIL;
          end
        end
        S_CHECK: begin
          r_cnt <= '0;
          if (w_crc_ok) begin
            r_temp  <= r_data[47:32];
            r_hum   <= r_data[23:8];
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_crc_err <= 1'b1;
            r_state   <= S_FAIL;
          end
        end
        S_FAIL: begin
          r_cnt <= '0;
          if (r_retry < RETRY_MAX) begin
            r_retry  <= r_retry + 8'd1;
            r_writes <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= S_WR_REQ;
          end else begin
            r_meas_fail <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Processor_Ready     = r_ready;
  assign i2c_writes          = r_writes;
  assign Peripheral_Address  = SHT_ADDR;
  assign Command_Data_Frames = r_cmd;
  assign Temperature_Output  = r_temp;
  assign Humidity_Output     = r_hum;
  assign Sample_Valid        = r_valid;
  assign CRC_Error           = r_crc_err;
  assign Meas_Fail           = r_meas_fail;
  assign Error_Count         = r_err_cnt;
  assign Busy                = (r_state != S_IDLE);

endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Scoreboard bench for sht40_measure_sequencer with a behavioural I2C master.
module tb_sht40_measure_sequencer;

  localparam int MEAS   = 20;
  localparam int PERIOD = 100;
  localparam int TO     = 50;

  localparam logic [47:0] GOOD1 = 48'hBEEF92ABCD6F;
  localparam logic [47:0] BAD1  = 48'hBEEF92ABCD6E;
  localparam logic [47:0] GOOD2 = 48'h000081BEEF92;

  localparam logic [3:0] EV_WR = 4'd1, EV_RD = 4'd2, EV_VALID = 4'd3,
                         EV_CRC = 4'd4, EV_FAIL = 4'd5;

  typedef struct packed {logic wr_nack; logic stuck; logic [47:0] bytes;} cfg_t;
  typedef struct packed {logic [3:0] kind; logic [31:0] val;} ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        Measure_Enable, Measure_Now;
  logic [1:0]  Precision_Sel;
  logic [2:0]  Master_State_Out;
  logic        Frames_Read;
  logic [7:0]  Data_Received;
  logic        Nack_Received;
  logic        Processor_Ready, i2c_writes;
  logic [6:0]  Peripheral_Address;
  logic [7:0]  Command_Data_Frames;
  logic [15:0] Temperature_Output, Humidity_Output;
  logic        Sample_Valid, CRC_Error, Meas_Fail;
  logic [7:0]  Error_Count;
  logic        Busy;

  sht40_measure_sequencer #(
    .SHT_ADDR(7'h44), .MEAS_WAIT_CYCLES(MEAS), .PERIOD_CYCLES(PERIOD),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(3)
  ) dut (
    .clk(clk), .rst(rst), .Measure_Enable(Measure_Enable), .Measure_Now(Measure_Now),
    .Precision_Sel(Precision_Sel), .Master_State_Out(Master_State_Out),
    .Frames_Read(Frames_Read), .Data_Received(Data_Received), .Nack_Received(Nack_Received),
    .Processor_Ready(Processor_Ready), .i2c_writes(i2c_writes),
    .Peripheral_Address(Peripheral_Address), .Command_Data_Frames(Command_Data_Frames),
    .Temperature_Output(Temperature_Output), .Humidity_Output(Humidity_Output),
    .Sample_Valid(Sample_Valid), .CRC_Error(CRC_Error), .Meas_Fail(Meas_Fail),
    .Error_Count(Error_Count), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   n_checks = 0, n_fail = 0;
  cfg_t cfg_q[$];
  ev_t  exp_q[$];

  // shared between master model, monitor and main sequence
  int   t_wr_done, t_rd_start, last_wr;
  logic wr_done_valid = 1'b0, wr_done_flag = 1'b0, stuck_armed = 1'b0;
  logic periodic = 1'b0, have_last_wr = 1'b0, model_busy = 1'b0;
  int   bytes_sent = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_meas(input logic [7:0] cmd, input logic [31:0] result);
    push(EV_WR, {24'h0, cmd});
    push(EV_RD, 32'h0);
    push(EV_VALID, result);
  endtask

  function automatic cfg_t mk(input logic nack, input logic stuck, input logic [47:0] b);
    cfg_t c;
    c.wr_nack = nack;
    c.stuck   = stuck;
    c.bytes   = b;
    return c;
  endfunction

  task automatic sb_event(input logic [3:0] kind, input logic [31:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d value %h, expected none (cycle %0d)", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event", {kind, val}, {e.kind, e.val});
    end
  endtask

  // Monitor: turns DUT outputs into events and checks request timing.
  logic prev_ready = 1'b0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (Processor_Ready && !prev_ready) begin
        if (i2c_writes) begin
          sb_event(EV_WR, {24'h0, Command_Data_Frames});
          if (stuck_armed) begin
            check("timeout_retry_delay",
                  40'(((cyc - t_rd_start) >= TO + 1) && ((cyc - t_rd_start) <= TO + 3)), 40'd1);
            stuck_armed = 1'b0;
          end
          if (periodic) begin
            if (have_last_wr) check("period_interval", 40'(cyc - last_wr), 40'(PERIOD));
            last_wr = cyc;
            have_last_wr = 1'b1;
          end
        end else begin
          sb_event(EV_RD, 32'h0);
          if (wr_done_valid) begin
            check("meas_wait_delay", 40'(cyc - t_wr_done), 40'(MEAS + 1));
            wr_done_valid = 1'b0;
          end
        end
      end
      prev_ready = Processor_Ready;
      if (Sample_Valid) sb_event(EV_VALID, {Temperature_Output, Humidity_Output});
      if (CRC_Error)    sb_event(EV_CRC,   {Temperature_Output, Humidity_Output});
      if (Meas_Fail)    sb_event(EV_FAIL,  {24'h0, Error_Count});
    end
  end

  // Behavioural i2c_master: one config popped per write request.
  initial begin : master_model
    cfg_t        cur;
    logic [47:0] sh;
    logic        pending;
    Master_State_Out = 3'b000;
    Frames_Read      = 1'b0;
    Data_Received    = 8'h00;
    Nack_Received    = 1'b0;
    cur              = mk(1'b0, 1'b0, 48'h0);
    pending          = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (Processor_Ready && !rst) begin
        model_busy = 1'b1;
        if (i2c_writes) begin
          cur = (cfg_q.size() > 0) ? cfg_q.pop_front() : mk(1'b0, 1'b0, 48'h0);
          Master_State_Out = 3'b001;
          repeat (3) @(negedge clk);
          if (cur.wr_nack) begin
            Nack_Received = 1'b1;
            @(negedge clk);
            Nack_Received = 1'b0;
          end
          Master_State_Out = 3'b000;
          if (!cur.wr_nack) begin
            t_wr_done = cyc;
            wr_done_valid = 1'b1;
          end
          wr_done_flag = 1'b1;
        end else begin
          Master_State_Out = 3'b010;
          bytes_sent = 0;
          if (cur.stuck) begin
            t_rd_start = cyc;
            stuck_armed = 1'b1;
            for (int i = 0; i < 200; i++) begin
              @(negedge clk);
              if (Processor_Ready) break;
            end
            pending = 1'b1;
          end else begin
            sh = cur.bytes;
            for (int b = 0; b < 6; b++) begin
              repeat (2) @(negedge clk);
              Frames_Read   = 1'b1;
              Data_Received = sh[47:40];
              sh = {sh[39:0], 8'h00};
              @(negedge clk);
              Frames_Read = 1'b0;
              bytes_sent++;
            end
            @(negedge clk);
            Master_State_Out = 3'b000;
          end
        end
        if (!pending) model_busy = 1'b0;
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || Busy || model_busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (i >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: not idle after %0d cycles, %0d events outstanding", name, budget, exp_q.size());
    end
  endtask

  task automatic pulse_now();
    Measure_Now = 1'b1;
    @(negedge clk);
    Measure_Now = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 40'(Processor_Ready), 40'd0);
    check("rst_busy", 40'(Busy), 40'd0);
    check("rst_writes", 40'(i2c_writes), 40'd1);
    check("rst_cmd", 40'(Command_Data_Frames), 40'hFD);
    check("rst_temp", 40'(Temperature_Output), 40'd0);
    check("rst_hum", 40'(Humidity_Output), 40'd0);
    check("rst_errcnt", 40'(Error_Count), 40'd0);
    check("rst_pulses", 40'({Sample_Valid, CRC_Error, Meas_Fail}), 40'd0);
  endtask

  initial begin : main
    int i;
    rst = 1'b1;
    Measure_Enable = 1'b0;
    Measure_Now    = 1'b0;
    Precision_Sel  = 2'd0;
    repeat (3) @(negedge clk);
    do_reset();
    check("addr", 40'(Peripheral_Address), 40'h44);

    // 1: good measurement
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD1));
    push_meas(8'hFD, 32'hBEEFABCD);
    pulse_now();
    wait_done("t1", 300);
    check("t1_busy", 40'(Busy), 40'd0);
    check("t1_temp", 40'(Temperature_Output), 40'hBEEF);

    // 2: CRC failure, held outputs, then good retry
    cfg_q.push_back(mk(1'b0, 1'b0, BAD1));
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD2));
    push(EV_WR, 32'hFD); push(EV_RD, 32'h0); push(EV_CRC, 32'hBEEFABCD);
    push_meas(8'hFD, 32'h0000BEEF);
    pulse_now();
    wait_done("t2", 400);

    // 3: NACK on every attempt -> 4 writes then Meas_Fail
    Precision_Sel = 2'd3;
    for (int k = 0; k < 4; k++) begin
      cfg_q.push_back(mk(1'b1, 1'b0, GOOD1));
      push(EV_WR, 32'hE0);
    end
    push(EV_FAIL, 32'd1);
    pulse_now();
    wait_done("t3", 400);
    check("t3_errcnt", 40'(Error_Count), 40'd1);
    check("t3_held_hum", 40'(Humidity_Output), 40'hBEEF);

    // 5: master stuck in read -> timeout, retry succeeds
    Precision_Sel = 2'd2;
    cfg_q.push_back(mk(1'b0, 1'b1, GOOD1));
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD1));
    push(EV_WR, 32'hE0); push(EV_RD, 32'h0);
    push_meas(8'hE0, 32'hBEEFABCD);
    pulse_now();
    wait_done("t5", 600);

    // 4: periodic triggering, Measure_Now while busy ignored
    Precision_Sel = 2'd1;
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD1));
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD2));
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD1));
    push_meas(8'hF6, 32'hBEEFABCD);
    push_meas(8'hF6, 32'h0000BEEF);
    push_meas(8'hF6, 32'hBEEFABCD);
    periodic = 1'b1;
    have_last_wr = 1'b0;
    Measure_Enable = 1'b1;
    i = 0;
    while (!Busy && i < 200) begin @(negedge clk); i++; end
    check("t4_started", 40'(Busy), 40'd1);
    repeat (10) @(negedge clk);
    pulse_now();
    wait_done("t4", 800);
    Measure_Enable = 1'b0;
    periodic = 1'b0;

    // 6a: reset during MEAS_WAIT
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD1));
    push(EV_WR, 32'hF6);
    wr_done_flag = 1'b0;
    pulse_now();
    i = 0;
    while (!wr_done_flag && i < 100) begin @(negedge clk); i++; end
    check("t6a_write_done", 40'(wr_done_flag), 40'd1);
    repeat (5) @(negedge clk);
    do_reset();
    Precision_Sel = 2'd0;
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD2));
    push_meas(8'hFD, 32'h0000BEEF);
    pulse_now();
    wait_done("t6a_clean", 300);

    // 6b: reset during RD_COLLECT
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD1));
    push(EV_WR, 32'hFD); push(EV_RD, 32'h0);
    bytes_sent = 0;
    pulse_now();
    i = 0;
    while (bytes_sent < 2 && i < 200) begin @(negedge clk); i++; end
    check("t6b_in_read", 40'(bytes_sent >= 2), 40'd1);
    do_reset();
    wait_done("t6b_drain", 100);
    cfg_q.push_back(mk(1'b0, 1'b0, GOOD1));
    push_meas(8'hFD, 32'hBEEFABCD);
    pulse_now();
    wait_done("t6b_clean", 300);

    repeat (5) @(negedge clk);
    check("events_outstanding", 40'(exp_q.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
